// File: rtl/wb_stream_writer_ctrl_if.sv
// Stream input and Wishbone master bundle for the stream writer DMA engine.
// The DUT takes the master modport; the stream source and bus slave take slave.
interface wb_stream_writer_ctrl_if #(
    parameter int WB_AW = 32,
    parameter int WB_DW = 32
);
    logic [WB_DW-1:0]   stream_s_data_i;
    logic               stream_s_valid_i;
    logic               stream_s_ready_o;

    logic [WB_AW-1:0]   wbm_adr_o;
    logic [WB_DW-1:0]   wbm_dat_o;
    logic [WB_DW/8-1:0] wbm_sel_o;
    logic               wbm_we_o;
    logic               wbm_cyc_o;
    logic               wbm_stb_o;
    logic [2:0]         wbm_cti_o;
    logic [1:0]         wbm_bte_o;
    logic               wbm_ack_i;
    logic               wbm_err_i;

    modport master (
        input  stream_s_data_i,
        input  stream_s_valid_i,
        output stream_s_ready_o,
        output wbm_adr_o,
        output wbm_dat_o,
        output wbm_sel_o,
        output wbm_we_o,
        output wbm_cyc_o,
        output wbm_stb_o,
        output wbm_cti_o,
        output wbm_bte_o,
        input  wbm_ack_i,
        input  wbm_err_i
    );

    modport slave (
        output stream_s_data_i,
        output stream_s_valid_i,
        input  stream_s_ready_o,
        input  wbm_adr_o,
        input  wbm_dat_o,
        input  wbm_sel_o,
        input  wbm_we_o,
        input  wbm_cyc_o,
        input  wbm_stb_o,
        input  wbm_cti_o,
        input  wbm_bte_o,
        output wbm_ack_i,
        output wbm_err_i
    );
endinterface

// File: rtl/wb_stream_writer_ctrl.sv
// Stream-to-Wishbone DMA write engine: FIFO plus incrementing burst writer.
// Define WB_STREAM_WRITER_ERR_EN to abort transfers on wbm_err_i (err_o).
module wb_stream_writer_ctrl #(
    parameter int WB_AW   = 32,
    parameter int WB_DW   = 32,
    parameter int FIFO_AW = 5
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    wb_stream_writer_ctrl_if.master bus,
    input  logic                 enable,
    input  logic [WB_AW-1:0]     start_adr,
    input  logic [WB_AW-1:0]     buf_size,
    input  logic [WB_AW-1:0]     burst_size,
    output logic                 busy,
    output logic [WB_DW-1:0]     tx_cnt,
    output logic                 err_o
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(DEPTH);
    localparam logic [WB_AW-1:0] DEPTH_W = WB_AW'(DEPTH);
    localparam logic [WB_AW-1:0] ONE_W = WB_AW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST,
        S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [WB_DW-1:0]   mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   fcnt_q;

    logic [WB_AW-1:0] base_q, base_d;
    logic [WB_AW-1:0] words_q, words_d;
    logic [WB_AW-1:0] blen_q, blen_d;
    logic [WB_AW-1:0] tx_q, tx_d;
    logic [WB_AW-1:0] beats_q, beats_d;
    logic             err_q, err_d;

    logic             cyc;
    logic             push;
    logic             pop;
    logic             full;
    logic             beat_ok;
    logic             beat_err;
    logic [WB_AW-1:0] rem;
    logic [WB_AW-1:0] beats_w;
    logic [WB_AW-1:0] fcnt_w;
    logic [WB_AW-1:0] words_in;
    logic             unused_bits;

    assign cyc = (state_q == S_BURST);

`ifdef WB_STREAM_WRITER_ERR_EN
    assign beat_ok  = cyc & bus.wbm_ack_i & ~bus.wbm_err_i;
    assign beat_err = cyc & bus.wbm_err_i;
`else
    assign beat_ok  = cyc & (bus.wbm_ack_i | bus.wbm_err_i);
    assign beat_err = 1'b0;
`endif

    assign pop  = beat_ok;
    assign full = (fcnt_q == FULL_CNT);
    // A full FIFO still takes a word when the head is written out this cycle.
    assign bus.stream_s_ready_o = wb_rst_ni & (~full | pop);
    assign push = bus.stream_s_valid_i & bus.stream_s_ready_o;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   fcnt_q <= fcnt_q + 1'b1;
                2'b01:   fcnt_q <= fcnt_q - 1'b1;
                default: fcnt_q <= fcnt_q;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push) mem_q[wr_ptr_q] <= bus.stream_s_data_i;
    end

    assign words_in    = {2'b00, buf_size[WB_AW-1:2]};
    assign fcnt_w      = WB_AW'(fcnt_q);
    assign unused_bits = ^buf_size[1:0];

    // Bursts never exceed the FIFO depth, otherwise WAIT could never be left.
    always_comb begin
        rem     = words_q - tx_q;
        beats_w = (blen_q < rem) ? blen_q : rem;
        if (beats_w > DEPTH_W) beats_w = DEPTH_W;
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        words_d = words_q;
        blen_d  = blen_q;
        tx_d    = tx_q;
        beats_d = beats_q;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    base_d  = start_adr;
                    words_d = words_in;
                    blen_d  = (burst_size == '0) ? ONE_W : burst_size;
                    tx_d    = '0;
                    state_d = (words_in == '0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (fcnt_w >= beats_w) begin
                    beats_d = beats_w;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (beat_err) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (beat_ok) begin
                    tx_d    = tx_q + ONE_W;
                    beats_d = beats_q - ONE_W;
                    if (beats_q == ONE_W) begin
                        state_d = (tx_d == words_q) ? S_DONE : S_WAIT;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            words_q <= '0;
            blen_q  <= '0;
            tx_q    <= '0;
            beats_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            words_q <= words_d;
            blen_q  <= blen_d;
            tx_q    <= tx_d;
            beats_q <= beats_d;
            err_q   <= err_d;
        end
    end

    assign bus.wbm_adr_o = base_q + {tx_q[WB_AW-3:0], 2'b00};
    assign bus.wbm_dat_o = mem_q[rd_ptr_q];
    assign bus.wbm_sel_o = '1;
    assign bus.wbm_we_o  = 1'b1;
    assign bus.wbm_cyc_o = cyc;
    assign bus.wbm_stb_o = cyc;
    assign bus.wbm_cti_o = !cyc ? 3'b000 :
                           (beats_q == ONE_W) ? 3'b111 : 3'b010;
    assign bus.wbm_bte_o = 2'b00;

    assign busy   = (state_q != S_IDLE);
    assign tx_cnt = WB_DW'(tx_q);

`ifdef WB_STREAM_WRITER_ERR_EN
    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_stream_writer_ctrl.sv
// Directed bench for wb_stream_writer_ctrl: bursts, tails, backpressure,
// edge cases, optional error abort and asynchronous reset mid-burst.
module tb_wb_stream_writer_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_stream_writer_ctrl_if bus();

    logic        enable;
    logic [31:0] start_adr;
    logic [31:0] buf_size;
    logic [31:0] burst_size;
    logic        busy;
    logic [31:0] tx_cnt;
    logic        err_o;

    wb_stream_writer_ctrl dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .bus        (bus),
        .enable     (enable),
        .start_adr  (start_adr),
        .buf_size   (buf_size),
        .burst_size (burst_size),
        .busy       (busy),
        .tx_cnt     (tx_cnt),
        .err_o      (err_o)
    );

    int total = 0;
    int bad = 0;

    logic ack_en = 1'b0;
    logic err_en = 1'b0;
    int   err_beat = -1;
    int   beat_n = 0;
    int   bursts = 0;
    int   err_pulses = 0;
    int   cycle_n = 0;
    int   last_ack = 0;
    logic cyc_d = 1'b0;

    logic [31:0] log_adr[$];
    logic [31:0] log_dat[$];
    logic [2:0]  log_cti[$];
    logic [31:0] src_q[$];

    assign bus.wbm_err_i = bus.wbm_cyc_o & err_en & (beat_n == err_beat);
    assign bus.wbm_ack_i = bus.wbm_cyc_o & ack_en & ~bus.wbm_err_i;

    always @(posedge clk) begin
        cycle_n <= cycle_n + 1;
        if (rst_n) begin
            if (bus.wbm_cyc_o && bus.wbm_ack_i) begin
                log_adr.push_back(bus.wbm_adr_o);
                log_dat.push_back(bus.wbm_dat_o);
                log_cti.push_back(bus.wbm_cti_o);
                beat_n   <= beat_n + 1;
                last_ack <= cycle_n + 1;
            end
            if (bus.wbm_cyc_o && !cyc_d) bursts <= bursts + 1;
            if (err_o) err_pulses <= err_pulses + 1;
            if (bus.stream_s_valid_i && bus.stream_s_ready_o && src_q.size() != 0)
                src_q.delete(0);
        end
        cyc_d <= bus.wbm_cyc_o;
    end

    always @(negedge clk) begin
        bus.stream_s_valid_i = (src_q.size() != 0);
        bus.stream_s_data_i  = (src_q.size() != 0) ? src_q[0] : 32'h0;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_log();
        log_adr.delete();
        log_dat.delete();
        log_cti.delete();
        beat_n     <= 0;
        bursts     <= 0;
        err_pulses <= 0;
    endtask

    task automatic push_words(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) src_q.push_back(base + 32'(i));
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] bs);
        enable     = 1'b1;
        start_adr  = a;
        buf_size   = b;
        burst_size = bs;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 300 && src_q.size() != 0; i++) @(negedge clk);
        chk(tag, 32'(src_q.size()), 32'd0);
    endtask

    task automatic wait_idle(input string tag, output int fall);
        for (int i = 0; i < 500 && busy; i++) @(negedge clk);
        fall = cycle_n;
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic check_beats(input string tag, input int n,
                               input logic [31:0] abase,
                               input logic [31:0] dbase, input int bl);
        chk({tag, "_nbeats"}, 32'(log_adr.size()), 32'(n));
        for (int i = 0; i < n && i < log_adr.size(); i++) begin
            int k;
            int nb;
            logic [2:0] ecti;
            k    = i / bl;
            nb   = (n - k * bl < bl) ? n - k * bl : bl;
            ecti = (i % bl == nb - 1) ? 3'b111 : 3'b010;
            chk($sformatf("%s_adr%0d", tag, i), log_adr[i], abase + 32'(4 * i));
            chk($sformatf("%s_dat%0d", tag, i), log_dat[i], dbase + 32'(i));
            chk($sformatf("%s_cti%0d", tag, i), 32'(log_cti[i]), 32'(ecti));
        end
    endtask

    initial begin
        int fall;
        enable = 1'b0;
        start_adr = '0;
        buf_size = '0;
        burst_size = '0;
        bus.stream_s_valid_i = 1'b0;
        bus.stream_s_data_i = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_txcnt", tx_cnt, 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(bus.wbm_stb_o), 32'd0);
        chk("rst_adr", bus.wbm_adr_o, 32'd0);
        chk("rst_cti", 32'(bus.wbm_cti_o), 32'd0);
        chk("rst_ready", 32'(bus.stream_s_ready_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.stream_s_ready_o), 32'd1);
        chk("const_we", 32'(bus.wbm_we_o), 32'd1);
        chk("const_sel", 32'(bus.wbm_sel_o), 32'hf);
        chk("const_bte", 32'(bus.wbm_bte_o), 32'd0);

        // basic: 16 words, bursts of 4
        clr_log();
        ack_en = 1'b1;
        push_words(32'hA000_0000, 16);
        wait_drain("basic_fill");
        start(32'h1000, 32'd64, 32'd4);
        chk("basic_busy_rise", 32'(busy), 32'd1);
        wait_idle("basic_busy_fall", fall);
        chk("basic_txcnt", tx_cnt, 32'd16);
        chk("basic_bursts", 32'(bursts), 32'd4);
        chk("basic_fall_lat", 32'(fall - last_ack), 32'd1);
        check_beats("basic", 16, 32'h1000, 32'hA000_0000, 4);

        // partial tail: 10 words -> 4,4,2
        clr_log();
        push_words(32'hB000_0000, 10);
        wait_drain("tail_fill");
        start(32'h1000, 32'd40, 32'd4);
        wait_idle("tail_busy_fall", fall);
        chk("tail_txcnt", tx_cnt, 32'd10);
        chk("tail_bursts", 32'(bursts), 32'd3);
        check_beats("tail", 10, 32'h1000, 32'hB000_0000, 4);

        // zero length
        clr_log();
        start(32'h5000, 32'd0, 32'd4);
        chk("zero_busy_hi", 32'(busy), 32'd1);
        @(negedge clk);
        chk("zero_busy_lo", 32'(busy), 32'd0);
        chk("zero_nocyc", 32'(bursts), 32'd0);
        chk("zero_txcnt", tx_cnt, 32'd0);

        // burst_size 0 plus enable while busy
        clr_log();
        start(32'h6000, 32'd12, 32'd0);
        chk("b0_busy", 32'(busy), 32'd1);
        start(32'h7000, 32'd400, 32'd8);
        repeat (3) @(negedge clk);
        chk("b0_waiting", 32'(busy), 32'd1);
        push_words(32'h6000_0000, 3);
        wait_drain("b0_fill");
        wait_idle("b0_busy_fall", fall);
        chk("b0_txcnt", tx_cnt, 32'd3);
        chk("b0_bursts", 32'(bursts), 32'd3);
        check_beats("b0", 3, 32'h6000, 32'h6000_0000, 1);

        // backpressure: slave stalls while the stream keeps pushing
        clr_log();
        ack_en = 1'b0;
        start(32'h2000, 32'd160, 32'd8);
        push_words(32'hC000_0000, 40);
        repeat (50) @(negedge clk);
        chk("bp_ready", 32'(bus.stream_s_ready_o), 32'd0);
        chk("bp_accepted", 32'(40 - src_q.size()), 32'd32);
        chk("bp_nobeats", 32'(log_adr.size()), 32'd0);
        chk("bp_cyc_held", 32'(bus.wbm_cyc_o), 32'd1);
        ack_en = 1'b1;
        wait_drain("bp_drain");
        wait_idle("bp_busy_fall", fall);
        chk("bp_txcnt", tx_cnt, 32'd40);
        check_beats("bp", 40, 32'h2000, 32'hC000_0000, 8);

`ifdef WB_STREAM_WRITER_ERR_EN
        // error on beat 3 of burst 2
        clr_log();
        push_words(32'hD000_0000, 8);
        wait_drain("err_fill");
        err_en = 1'b1;
        err_beat = 6;
        start(32'h3000, 32'd32, 32'd4);
        wait_idle("err_busy_fall", fall);
        chk("err_txcnt", tx_cnt, 32'd6);
        chk("err_pulses", 32'(err_pulses), 32'd1);
        chk("err_nbeats", 32'(log_adr.size()), 32'd6);
        err_en = 1'b0;
        err_beat = -1;
        @(negedge clk);
        clr_log();
        start(32'h4000, 32'd8, 32'd2);
        wait_idle("err_left_fall", fall);
        chk("err_left_txcnt", tx_cnt, 32'd2);
        check_beats("err_left", 2, 32'h4000, 32'hD000_0006, 2);
`endif

        // asynchronous reset in the middle of a stalled burst
        clr_log();
        ack_en = 1'b0;
        push_words(32'hE000_0000, 8);
        wait_drain("rm_fill");
        start(32'h8000, 32'd32, 32'd4);
        for (int i = 0; i < 20 && !bus.wbm_cyc_o; i++) @(negedge clk);
        chk("rm_cyc_before", 32'(bus.wbm_cyc_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_cyc_async", 32'(bus.wbm_cyc_o), 32'd0);
        chk("rm_stb_async", 32'(bus.wbm_stb_o), 32'd0);
        chk("rm_busy", 32'(busy), 32'd0);
        chk("rm_ready_low", 32'(bus.stream_s_ready_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rm_ready_high", 32'(bus.stream_s_ready_o), 32'd1);
        chk("rm_txcnt", tx_cnt, 32'd0);
        @(negedge clk);
        clr_log();
        ack_en = 1'b1;
        start(32'h9000, 32'd4, 32'd1);
        repeat (10) @(negedge clk);
        chk("rm_fifo_empty", 32'(log_adr.size()), 32'd0);
        chk("rm_still_wait", 32'(busy), 32'd1);
        push_words(32'h0000_F00D, 1);
        wait_drain("rm_fill2");
        wait_idle("rm_busy_fall", fall);
        check_beats("rm", 1, 32'h9000, 32'h0000_F00D, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
